bcd_divider: RTL and testbench
==============================

Name: bcd_divider

Overview:
Sequential 4-digit packed-BCD integer divider.
- Captures a 16-bit BCD dividend and divisor on a start pulse.
- Performs digit-serial restoring long division (shift one BCD digit, then repeated BCD subtraction).
- Presents a 4-digit BCD quotient and remainder with a completion flag.
- Used as a standalone arithmetic co-unit in the SD1 datapath; one division in flight at a time.

Parameters:
None. Width is fixed at 4 BCD digits (16 bits).

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  begin a division; sampled on rising clk in IDLE or DONE
dividend  input  16  4-digit packed BCD dividend, digit 3 in [15:12]
divisor  input  16  4-digit packed BCD divisor
quotient  output  16  4-digit packed BCD quotient
remainder  output  16  4-digit packed BCD remainder
end_division  output  1  high while a valid result is held

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - quotient=0000, remainder=0000, end_division=0.
  - All internal registers cleared.
  - Reset mid-division aborts it; no result is produced.
- Internal registers:
  - D: captured dividend.
  - V: captured divisor.
  - R: 20-bit, 5-digit partial remainder.
  - qd: 4-bit digit counter.
  - idx: 2-bit digit index.
  - Q: quotient accumulator.
- IDLE, or DONE with start=1:
  - Capture D=dividend, V=divisor; clear R, Q, qd; set idx=3; end_division<=0.
  - If V==0000: next state DIVZERO. Otherwise next state SHIFT.
  - Inputs may change freely after the capture edge.
- DIVZERO (one cycle):
  - quotient<=9999, remainder<=D, end_division<=1.
  - Next state DONE.
- SHIFT (one cycle):
  - R <= {R[15:0], D digit idx}, i.e. R*10 + digit.
  - qd<=0.
  - Next state SUB.
- SUB:
  - If R >= {0,V} (packed-BCD magnitude compare, identical to unsigned compare): R <= R - V using digit-wise BCD subtraction with borrow; qd <= qd+1; stay in SUB.
  - Else: Q digit idx <= qd. If idx==0, then quotient<=Q (with the final digit), remainder<=R[15:0], end_division<=1, next state DONE. Otherwise idx<=idx-1, next state SHIFT.
  - qd never exceeds 9, because R < 10*V is invariant.
- DONE:
  - Outputs and end_division hold until reset or the next start.
  - start here behaves exactly as in IDLE; end_division drops on the capture edge.
- start while in SHIFT, SUB or DIVZERO is ignored.
- quotient and remainder change only on completion or reset, never during computation.
- Latency, counted in rising edges from the start-capture edge to end_division high:
  - Normal: 8 + sum of the quotient digits. Minimum 8, maximum 44.
  - Divide-by-zero: 2.
- Input digits >9 are not detected. The result for such inputs is unspecified, and the verifier must not check it.
- Invariant for every valid non-zero divisor: dividend = quotient*divisor + remainder, with remainder < divisor, all values in decimal.

Test Plan:
- 0144/0009 -> quotient 0016, remainder 0000; end_division high 15 edges after capture.
- 0150/0004 -> 0037 R 0002. 0200/0002 -> 0100 R 0000. 0025/0007 -> 0003 R 0004. 0123/0004 -> 0030 R 0003. Check latency = 8 + digit sum in each case.
- 0100/0000 -> quotient 9999, remainder 0100, end_division high 2 edges after capture. 0000/0005 -> 0000 R 0000 after 8 edges.
- 9999/0001 -> 9999 R 0000 after 44 edges (maximum latency). Then issue 0099/0009 from DONE without reset: end_division drops on the capture edge; result 0011 R 0000.
- Pull rst low mid-division on 0050/0003: outputs are 0000/0000 with end_division=0 immediately, asynchronously. Pulsing start during SUB has no effect. After reset, 0050/0003 -> 0016 R 0002.

Source files
------------

// File: rtl/bcd_divider.sv
// ============================================================================
// Module   : bcd_divider
// Brief    : Sequential 4-digit packed-BCD divider. Restoring long division,
//            one BCD digit at a time: shift a dividend digit into the partial
//            remainder, then subtract the divisor repeatedly with BCD borrow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_divider (
  input  logic        clk,
  input  logic        rst,           // asynchronous, active-low
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        end_division
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DZ_WAIT = 3'd1,
    S_DIVZERO = 3'd2,
    S_SHIFT   = 3'd3,
    S_SUB     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam int unsigned C_DIGITS = 5;   // partial remainder is 5 BCD digits

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_d;      // captured dividend
  logic [15:0] r_v;      // captured divisor
  logic [19:0] r_rem;    // partial remainder
  logic [15:0] r_q;      // quotient accumulator
  logic [3:0]  r_qd;     // subtractions done for the current digit
  logic [1:0]  r_idx;    // dividend/quotient digit being processed

  logic        w_capture;
  logic [3:0]  w_digit;
  logic [19:0] w_vx;
  logic        w_ge;
  logic [19:0] w_diff;
  logic [4:0]  w_t;
  logic        w_brw;

  // A new division is accepted only from IDLE or DONE
  assign w_capture = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Dividend digit selected by the current index, and zero-extended divisor
  assign w_digit = r_d[{r_idx, 2'b00} +: 4];
  assign w_vx    = {4'd0, r_v};

  // Packed BCD orders the same as plain binary, so an unsigned compare suffices
  assign w_ge = (r_rem >= w_vx);

  // Digit-wise BCD subtraction with ripple borrow: r_rem - divisor
  always_comb begin
    w_diff = '0;
    w_t    = '0;
    w_brw  = 1'b0;
    for (int i = 0; i < C_DIGITS; i++) begin
      w_t = {1'b0, r_rem[i*4 +: 4]} - {1'b0, w_vx[i*4 +: 4]} - {4'd0, w_brw};
      w_diff[i*4 +: 4] = w_t[4] ? (w_t[3:0] + 4'd10) : w_t[3:0];
      w_brw = w_t[4];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next = (divisor == 16'h0000) ? S_DZ_WAIT : S_SHIFT;
        end
      end
      // Divide-by-zero reports on the second edge after capture
      S_DZ_WAIT: w_next = S_DIVZERO;
      S_DIVZERO: w_next = S_DONE;
      S_SHIFT:   w_next = S_SUB;
      S_SUB: begin
        if (!w_ge) begin
          w_next = (r_idx == 2'd0) ? S_DONE : S_SHIFT;
        end
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // Datapath and result registers; results move only on completion or reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d          <= '0;
      r_v          <= '0;
      r_rem        <= '0;
      r_q          <= '0;
      r_qd         <= '0;
      r_idx        <= '0;
      quotient     <= '0;
      remainder    <= '0;
      end_division <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_capture) begin
            r_d          <= dividend;
            r_v          <= divisor;
            r_rem        <= '0;
            r_q          <= '0;
            r_qd         <= '0;
            r_idx        <= 2'd3;
            end_division <= 1'b0;
          end
        end
        S_DIVZERO: begin
          quotient     <= 16'h9999;
          remainder    <= r_d;
          end_division <= 1'b1;
        end
        S_SHIFT: begin
          r_rem <= {r_rem[15:0], w_digit};
          r_qd  <= 4'd0;
        end
        S_SUB: begin
          if (w_ge) begin
            r_rem <= w_diff;
            r_qd  <= r_qd + 4'd1;
          end else begin
            r_q[{r_idx, 2'b00} +: 4] <= r_qd;
            if (r_idx == 2'd0) begin
              quotient     <= {r_q[15:4], r_qd};
              remainder    <= r_rem[15:0];
              end_division <= 1'b1;
            end else begin
              r_idx <= r_idx - 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_divider.sv
// ============================================================================
// Module   : tb_bcd_divider
// Brief    : Self-checking bench for bcd_divider against a decimal reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        end_division;

  int          n_vec;
  int          n_err;
  logic [15:0] last_q;
  logic [15:0] last_r;

  bcd_divider dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .dividend     (dividend),
    .divisor      (divisor),
    .quotient     (quotient),
    .remainder    (remainder),
    .end_division (end_division)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  // One division; poke>0 pulses start with junk operands after that many edges
  task automatic run_div(input logic [15:0] dd, input logic [15:0] dv, input int poke);
    logic [15:0] eq, er;
    int          exp_lat, lat;
    bit          done, moved;
    if (bcd2int(dv) == 0) begin
      eq      = 16'h9999;
      er      = dd;
      exp_lat = 2;
    end else begin
      eq      = int2bcd(bcd2int(dd) / bcd2int(dv));
      er      = int2bcd(bcd2int(dd) % bcd2int(dv));
      exp_lat = 8 + int'(eq[15:12]) + int'(eq[11:8]) + int'(eq[7:4]) + int'(eq[3:0]);
    end
    @(negedge clk);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    check("ack_drop", {31'd0, end_division}, 32'd0);
    lat   = 0;
    done  = 1'b0;
    moved = 1'b0;
    while (!done && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      start = 1'b0;
      if (end_division) begin
        done = 1'b1;
      end else begin
        if (quotient !== last_q || remainder !== last_r) moved = 1'b1;
        if (poke > 0 && lat == poke) begin
          start    = 1'b1;
          dividend = 16'h0001;
          divisor  = 16'h0000;
        end
      end
    end
    start = 1'b0;
    check("latency", lat, exp_lat);
    check("quotient", {16'd0, quotient}, {16'd0, eq});
    check("remainder", {16'd0, remainder}, {16'd0, er});
    check("hold_busy", {31'd0, moved}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("done_hold", {15'd0, end_division, quotient}, {15'd0, 1'b1, eq});
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    last_q   = 16'h0000;
    last_r   = 16'h0000;
    rst      = 1'b0;
    start    = 1'b0;
    dividend = 16'h0000;
    divisor  = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out", {15'd0, end_division, quotient}, 32'd0);
    check("rst_rem", {16'd0, remainder}, 32'd0);
    rst = 1'b1;

    // Directed cases
    run_div(16'h0144, 16'h0009, 0);
    run_div(16'h0150, 16'h0004, 0);
    run_div(16'h0200, 16'h0002, 0);
    run_div(16'h0025, 16'h0007, 0);
    run_div(16'h0123, 16'h0004, 0);
    run_div(16'h0100, 16'h0000, 0);
    run_div(16'h0000, 16'h0005, 0);
    run_div(16'h9999, 16'h0001, 0);
    run_div(16'h0099, 16'h0009, 0);
    // start pulsed mid-computation must be ignored
    run_div(16'h0144, 16'h0009, 5);

    // Asynchronous reset mid-division
    @(negedge clk);
    start    = 1'b1;
    dividend = 16'h0050;
    divisor  = 16'h0003;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_q", {15'd0, end_division, quotient}, 32'd0);
    check("arst_r", {16'd0, remainder}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b1;
    last_q = 16'h0000;
    last_r = 16'h0000;
    run_div(16'h0050, 16'h0003, 0);

    // Randomized operands with valid BCD digits
    for (int k = 0; k < 40; k++) begin
      int nd, vmax;
      nd   = int'($urandom_range(1, 4));
      vmax = (nd == 1) ? 9 : (nd == 2) ? 99 : (nd == 3) ? 999 : 9999;
      run_div(int2bcd(int'($urandom_range(0, 9999))),
              int2bcd(int'($urandom_range(0, vmax))), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
